// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz VGA timing constants shared by the sync generator,
// the character generator and the pixel colour mux.
package vga_timing_pkg;

    // Pixel clock divider: 100 MHz board clock / 4 = 25 MHz pixel rate
    localparam int TICK_DIV     = 4;

    // Horizontal timing in pixels
    localparam int H_DISPLAY    = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;   // 800

    // Vertical timing in lines
    localparam int V_DISPLAY    = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;   // 525

    // Sync pulse windows (inclusive), expressed as counter values
    localparam int H_SYNC_START = H_DISPLAY + H_FP;                    // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;           // 751
    localparam int V_SYNC_START = V_DISPLAY + V_FP;                    // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;           // 491

    // Half-period of the cursor blink, in frames
    localparam int BLINK_FRAMES = 30;

    // Width of the pixel_x / pixel_y coordinate buses
    localparam int COORD_W      = 10;

    // True when lo <= v <= hi
    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/contador_mod_m.sv
// Generic mod-M counter: counts 0..M-1 while en is high and wraps.
// max_tick is a combinational flag that the count sits at M-1.
module contador_mod_m #(
    parameter int M = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic max_tick
);

    localparam int             W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0]   LAST = W'(M - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold, increment, or wrap to zero after M-1
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign max_tick = (count_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, horizontal/vertical
// counters, registered active-low syncs, frame_start pulse and the
// ~1 Hz cursor blink (parpadeo).
module vga_sync_gen #(
    parameter int TICK_DIV     = vga_timing_pkg::TICK_DIV,
    parameter int H_DISPLAY    = vga_timing_pkg::H_DISPLAY,
    parameter int H_FP         = vga_timing_pkg::H_FP,
    parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
    parameter int H_BP         = vga_timing_pkg::H_BP,
    parameter int V_DISPLAY    = vga_timing_pkg::V_DISPLAY,
    parameter int V_FP         = vga_timing_pkg::V_FP,
    parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
    parameter int V_BP         = vga_timing_pkg::V_BP,
    parameter int BLINK_FRAMES = vga_timing_pkg::BLINK_FRAMES
) (
    input  logic                               clk,
    input  logic                               reset_n,
    output logic                               p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_x,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_y,
    output logic                               video_on,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               frame_start,
    output logic                               parpadeo
);

    import vga_timing_pkg::*;

    localparam int H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int HW           = $clog2(H_TOTAL);
    localparam int VW           = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;
    logic          parpadeo_q, parpadeo_d;
    logic          line_end;
    logic          frame_wrap;
    logic          frame_max;

    // Pixel-enable divider: p_tick is high while the divider sits at TICK_DIV-1
    contador_mod_m #(
        .M        (TICK_DIV)
    ) u_tick_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (1'b1),
        .max_tick (p_tick)
    );

    // Frame counter for the blink; advances once per frame wrap
    contador_mod_m #(
        .M        (BLINK_FRAMES)
    ) u_blink_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (frame_wrap),
        .max_tick (frame_max)
    );

    // Next-state counters and sync decode; syncs use the next counter
    // values so the registered syncs line up with pixel_x/pixel_y
    always_comb begin
        line_end      = p_tick && (int'(h_cnt_q) == H_TOTAL - 1);
        frame_wrap    = line_end && (int'(v_cnt_q) == V_TOTAL - 1);

        h_cnt_d       = h_cnt_q;
        if (p_tick) begin
            h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
        end

        v_cnt_d       = v_cnt_q;
        if (line_end) begin
            v_cnt_d = frame_wrap ? '0 : v_cnt_q + 1'b1;
        end

        hsync_d       = !in_window(int'(h_cnt_d), H_SYNC_START, H_SYNC_END);
        vsync_d       = !in_window(int'(v_cnt_d), V_SYNC_START, V_SYNC_END);
        frame_start_d = frame_wrap;
        parpadeo_d    = parpadeo_q ^ (frame_wrap && frame_max);
    end

    // Timing state; reset returns to (0,0) with syncs idle high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            parpadeo_q    <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            parpadeo_q    <= parpadeo_d;
        end
    end

    assign pixel_x     = COORD_W'(h_cnt_q);
    assign pixel_y     = COORD_W'(v_cnt_q);
    assign video_on    = (int'(h_cnt_q) < H_DISPLAY) && (int'(v_cnt_q) < V_DISPLAY);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign parpadeo    = parpadeo_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances: the default 640x480 timing
// (line-level behaviour, mid-line reset) and a shrunken timing so that
// vsync, frame_start and several blink periods fit in a short run.
// Each cycle the stimulus pushes the expected output word of both
// instances; the monitor pops it on the falling edge and compares.
module tb_vga_sync_gen;

    // Shrunken timing: 16 x 10 total, 2 clk per pixel, blink every 3 frames
    localparam int S_TD = 2;
    localparam int S_HD = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 3;
    localparam int S_VD = 6;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;
    localparam int S_BF = 3;

    localparam int N_CYCLES = 9300;

    // ---------------- clock / reset ----------------
    logic clk;
    logic f_reset_n;
    logic s_reset_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    logic       f_p_tick, f_video_on, f_hsync, f_vsync, f_frame_start, f_parpadeo;
    logic [9:0] f_pixel_x, f_pixel_y;
    logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start, s_parpadeo;
    logic [9:0] s_pixel_x, s_pixel_y;

    vga_sync_gen u_dut_full (
        .clk         (clk),
        .reset_n     (f_reset_n),
        .p_tick      (f_p_tick),
        .pixel_x     (f_pixel_x),
        .pixel_y     (f_pixel_y),
        .video_on    (f_video_on),
        .hsync       (f_hsync),
        .vsync       (f_vsync),
        .frame_start (f_frame_start),
        .parpadeo    (f_parpadeo)
    );

    vga_sync_gen #(
        .TICK_DIV     (S_TD),
        .H_DISPLAY    (S_HD),
        .H_FP         (S_HF),
        .H_SYNC       (S_HS),
        .H_BP         (S_HB),
        .V_DISPLAY    (S_VD),
        .V_FP         (S_VF),
        .V_SYNC       (S_VS),
        .V_BP         (S_VB),
        .BLINK_FRAMES (S_BF)
    ) u_dut_small (
        .clk         (clk),
        .reset_n     (s_reset_n),
        .p_tick      (s_p_tick),
        .pixel_x     (s_pixel_x),
        .pixel_y     (s_pixel_y),
        .video_on    (s_video_on),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .frame_start (s_frame_start),
        .parpadeo    (s_parpadeo)
    );

    // ---------------- expected-value model ----------------
    // k = clk cycles since reset release (the release cycle is k=0; any
    // cycle spent in reset also looks like k=0). Pixel index p = k/td.
    // Word layout: {p_tick, x[9:0], y[9:0], video_on, hsync, vsync, frame_start, parpadeo}
    function automatic logic [25:0] model(input int k, input int td,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb,
                                          input int bf);
        int   ht, vt, p, x, y, f;
        logic pt, von, hs_n, vs_n, fs, bl;
        ht   = hd + hf + hs + hb;
        vt   = vd + vf + vs + vb;
        p    = k / td;
        x    = p % ht;
        y    = (p / ht) % vt;
        f    = p / (ht * vt);
        pt   = ((k % td) == td - 1);
        von  = (x < hd) && (y < vd);
        hs_n = !((x >= hd + hf) && (x < hd + hf + hs));
        vs_n = !((y >= vd + vf) && (y < vd + vf + vs));
        fs   = (p > 0) && ((p % (ht * vt)) == 0) && ((k % td) == 0);
        bl   = ((f / bf) % 2) == 1;
        return {pt, 10'(x), 10'(y), von, hs_n, vs_n, fs, bl};
    endfunction

    // ---------------- scoreboard ----------------
    logic [51:0] exp_q[$];
    int          checks;
    int          failures;
    int          cyc;

    // Monitor: pops one expected word per cycle and compares both DUTs
    initial begin
        logic [51:0] exp_w;
        logic [25:0] act_f, act_s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                act_f = {f_p_tick, f_pixel_x, f_pixel_y, f_video_on, f_hsync, f_vsync,
                         f_frame_start, f_parpadeo};
                act_s = {s_p_tick, s_pixel_x, s_pixel_y, s_video_on, s_hsync, s_vsync,
                         s_frame_start, s_parpadeo};
                checks++;
                if (act_f !== exp_w[51:26]) begin
                    failures++;
                    $display("FAIL full_timing cyc=%0d actual=%h expected=%h", cyc, act_f, exp_w[51:26]);
                end
                checks++;
                if (act_s !== exp_w[25:0]) begin
                    failures++;
                    $display("FAIL small_timing cyc=%0d actual=%h expected=%h", cyc, act_s, exp_w[25:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Full instance: released at cycle 3, reset again when x=700,y=2
    // (k=9200, hsync low). Small instance: released at cycle 3, reset
    // again at x=11,y=7 of frame 13 (k=4406, hsync and vsync both low).
    task automatic drive_resets(input int c);
        f_reset_n = !((c < 3) || ((c >= 9203) && (c < 9206)));
        s_reset_n = !((c < 3) || ((c >= 4409) && (c < 4412)));
    endtask

    initial begin
        int k_f;
        int k_s;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        k_f       = 0;
        k_s       = 0;
        f_reset_n = 1'b0;
        s_reset_n = 1'b0;
        for (int c = 0; c < N_CYCLES; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive_resets(c);
            if (!f_reset_n) k_f = 0;
            if (!s_reset_n) k_s = 0;
            exp_q.push_back({model(k_f, 4, 640, 16, 96, 48, 480, 10, 2, 33, 30),
                             model(k_s, S_TD, S_HD, S_HF, S_HS, S_HB,
                                   S_VD, S_VF, S_VS, S_VB, S_BF)});
            k_f = f_reset_n ? k_f + 1 : 0;
            k_s = s_reset_n ? k_s + 1 : 0;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
